// File: rtl/ext_int_pkg.sv
// Shared types for the external interrupt controller:
// sense encodings, channel state and the priority encoder.
package ext_int_pkg;

   localparam logic [1:0] SENSE_RISE  = 2'b00;
   localparam logic [1:0] SENSE_FALL  = 2'b01;
   localparam logic [1:0] SENSE_CHG   = 2'b10;
   localparam logic [1:0] SENSE_LOW   = 2'b11;

   typedef enum logic {
      CH_IDLE,
      CH_LOCKOUT
   } ch_state_t;

   // Lowest set bit index of v, 0 when v is all zeros.
   function automatic logic [4:0] lowest_idx(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ext_int_controller_if.sv
// Interrupt-side bus of the controller: pending flags,
// irq request/id, acknowledge and write-1-to-clear.
interface ext_int_controller_if #(
   parameter int NUM_CH = 4,
   parameter int IDW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pending_clr;
   logic              irq_valid;
   logic [IDW-1:0]    irq_id;
   logic              irq_ack;

   modport master (
      output pending, irq_valid, irq_id,
      input  pending_clr, irq_ack
   );

   modport slave (
      input  pending, irq_valid, irq_id,
      output pending_clr, irq_ack
   );
endinterface

// File: rtl/ext_int_channel.sv
// One interrupt channel: pin synchronizer, edge/level
// detect and a debounce lockout FSM with its counter.
module ext_int_channel
   import ext_int_pkg::*;
#(
   parameter logic IDLE_LVL   = 1'b1,
   parameter int   DEBOUNCE_W = 16,
   parameter int   SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_pin,
   input  logic                  i_enable,
   input  logic [1:0]            i_sense,
   input  logic                  i_deb_en,
   input  logic [DEBOUNCE_W-1:0] i_deb_limit,
   output logic                  o_evt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   ch_state_t              r_state;
   logic [DEBOUNCE_W-1:0]  r_cnt;

   ch_state_t             w_state_nxt;
   logic [DEBOUNCE_W-1:0] w_cnt_nxt;
   logic [DEBOUNCE_W-1:0] w_lim_m1;
   logic                  w_sync;
   logic                  w_edge;
   logic                  w_level;
   logic                  w_lock_ok;

   assign w_sync    = r_sync[SYNC_STAGES-1];
   assign w_lim_m1  = i_deb_limit - DEBOUNCE_W'(1);
   assign w_lock_ok = i_deb_en && (i_deb_limit != '0);
   assign w_level   = (i_sense == SENSE_LOW) && !w_sync;

   // Select the edge event for the configured sense mode.
   always_comb begin
      w_edge = 1'b0;
      unique case (i_sense)
         SENSE_RISE: w_edge = !r_prev && w_sync;
         SENSE_FALL: w_edge = r_prev && !w_sync;
         SENSE_CHG:  w_edge = r_prev ^ w_sync;
         SENSE_LOW:  w_edge = 1'b0;
      endcase
   end

   // Next-state, counter and event output of the lockout FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_evt       = 1'b0;
      if (!i_enable) begin
         w_state_nxt = CH_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            CH_IDLE: begin
               o_evt = w_edge || w_level;
               if (w_edge && w_lock_ok) begin
                  w_state_nxt = CH_LOCKOUT;
                  w_cnt_nxt   = '0;
               end
            end
            CH_LOCKOUT: begin
               o_evt     = w_level;
               w_cnt_nxt = r_cnt + DEBOUNCE_W'(1);
               if (i_deb_limit == '0 || r_cnt == w_lim_m1) begin
                  w_state_nxt = CH_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
         endcase
      end
   end

   // Synchronizer, previous level and FSM registers; prev
   // follows sync so lockout exit and re-enable see no stale edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync  <= {SYNC_STAGES{IDLE_LVL}};
         r_prev  <= IDLE_LVL;
         r_state <= CH_IDLE;
         r_cnt   <= '0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_prev  <= w_sync;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/ext_int_controller.sv
// External interrupt controller top: per-channel detectors,
// sticky pending flags with clear/ack and a priority encoder.
module ext_int_controller
   import ext_int_pkg::*;
#(
   parameter int                NUM_CH         = 4,
   parameter logic [NUM_CH-1:0] PIN_IDLE_STATE = '1,
   parameter int                DEBOUNCE_W     = 16,
   parameter int                SYNC_STAGES    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     int_pin,
   input  logic [NUM_CH-1:0]     enable,
   input  logic [2*NUM_CH-1:0]   sense_ctrl,
   input  logic [NUM_CH-1:0]     debounce_en,
   input  logic [DEBOUNCE_W-1:0] debounce_limit,
   ext_int_controller_if.master  irq
);

   localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] r_pending;
   logic [NUM_CH-1:0] w_evt;
   logic [NUM_CH-1:0] w_ack_oh;
   logic [31:0]       w_pend32;
   logic [4:0]        w_idx;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ext_int_channel #(
         .IDLE_LVL    (PIN_IDLE_STATE[g]),
         .DEBOUNCE_W  (DEBOUNCE_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_pin       (int_pin[g]),
         .i_enable    (enable[g]),
         .i_sense     (sense_ctrl[2*g+1:2*g]),
         .i_deb_en    (debounce_en[g]),
         .i_deb_limit (debounce_limit),
         .o_evt       (w_evt[g])
      );
   end

   // Lowest-index priority over the pending flags.
   always_comb begin
      w_pend32               = '0;
      w_pend32[NUM_CH-1:0]   = r_pending;
      w_idx                  = lowest_idx(w_pend32);
   end

   assign irq.pending   = r_pending;
   assign irq.irq_valid = |r_pending;
   assign irq.irq_id    = w_idx[IDW-1:0];

   // One-hot clear from an acknowledge of the granted channel.
   always_comb begin
      w_ack_oh = '0;
      if (irq.irq_ack && irq.irq_valid) begin
         w_ack_oh[irq.irq_id] = 1'b1;
      end
   end

   // Sticky pending: a new event beats a same-cycle clear,
   // disabled channels are held at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= ((r_pending & ~(irq.pending_clr | w_ack_oh))
                       | w_evt) & enable;
      end
   end

endmodule

// File: tb/tb_ext_int_controller.sv
// Directed bench for ext_int_controller: edge, debounce,
// ack priority, set-vs-clear, level mode and reset abort.
module tb_ext_int_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  int_pin;
   logic [3:0]  enable;
   logic [7:0]  sense_ctrl;
   logic [3:0]  debounce_en;
   logic [15:0] debounce_limit;

   int n_chk  = 0;
   int n_pass = 0;

   ext_int_controller_if #(.NUM_CH(4)) irq_if ();

   ext_int_controller #(
      .NUM_CH         (4),
      .PIN_IDLE_STATE (4'hF),
      .DEBOUNCE_W     (16),
      .SYNC_STAGES    (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .int_pin        (int_pin),
      .enable         (enable),
      .sense_ctrl     (sense_ctrl),
      .debounce_en    (debounce_en),
      .debounce_limit (debounce_limit),
      .irq            (irq_if)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   initial begin
      rst_n              = 1'b0;
      int_pin            = 4'hF;
      enable             = 4'h0;
      sense_ctrl         = 8'h54;
      debounce_en        = 4'h0;
      debounce_limit     = 16'd0;
      irq_if.pending_clr = 4'h0;
      irq_if.irq_ack     = 1'b0;
      tick(2);
      rst_n = 1'b1;
      chk("rst_pend", 32'(irq_if.pending), 32'h0);
      chk("rst_valid", 32'(irq_if.irq_valid), 32'h0);
      chk("rst_id", 32'(irq_if.irq_id), 32'h0);

      // ch0 rising edge, no debounce
      enable = 4'h1;
      int_pin = 4'hE;
      tick(5);
      chk("rise_nofall", 32'(irq_if.pending), 32'h0);
      int_pin = 4'hF;
      tick(2);
      chk("rise_lat2", 32'(irq_if.pending), 32'h0);
      tick(1);
      chk("rise_lat3", 32'(irq_if.pending), 32'h1);
      chk("rise_valid", 32'(irq_if.irq_valid), 32'h1);
      chk("rise_id", 32'(irq_if.irq_id), 32'h0);
      irq_if.pending_clr = 4'h1;
      tick(1);
      irq_if.pending_clr = 4'h0;
      chk("rise_clr", 32'(irq_if.pending), 32'h0);

      // ch1 falling edge with bounce inside lockout
      enable = 4'h3;
      debounce_en = 4'h2;
      debounce_limit = 16'd10;
      int_pin[1] = 1'b0; tick(1);
      int_pin[1] = 1'b1; tick(1);
      int_pin[1] = 1'b0; tick(1);
      int_pin[1] = 1'b1; tick(1);
      int_pin[1] = 1'b0; tick(1);
      chk("deb_set", 32'(irq_if.pending), 32'h2);
      chk("deb_id", 32'(irq_if.irq_id), 32'h1);
      irq_if.pending_clr = 4'h2;
      tick(1);
      irq_if.pending_clr = 4'h0;
      chk("deb_clr", 32'(irq_if.pending), 32'h0);
      tick(20);
      chk("deb_quiet", 32'(irq_if.pending), 32'h0);
      debounce_en = 4'h0;

      // ch2 and ch3 acknowledged in priority order
      enable = 4'hC;
      int_pin[3:2] = 2'b00;
      tick(3);
      chk("ack_pend", 32'(irq_if.pending), 32'hC);
      chk("ack_id0", 32'(irq_if.irq_id), 32'h2);
      irq_if.irq_ack = 1'b1;
      tick(1);
      irq_if.irq_ack = 1'b0;
      chk("ack_pend1", 32'(irq_if.pending), 32'h8);
      chk("ack_id1", 32'(irq_if.irq_id), 32'h3);
      irq_if.irq_ack = 1'b1;
      tick(1);
      irq_if.irq_ack = 1'b0;
      chk("ack_valid", 32'(irq_if.irq_valid), 32'h0);
      chk("ack_pend2", 32'(irq_if.pending), 32'h0);
      int_pin[3:2] = 2'b11;

      // ch0 change mode, set wins over same-cycle clear
      enable = 4'h1;
      sense_ctrl = 8'h56;
      int_pin[0] = 1'b0;
      tick(3);
      chk("chg_fall", 32'(irq_if.pending), 32'h1);
      int_pin[0] = 1'b1;
      tick(2);
      irq_if.pending_clr = 4'h1;
      tick(1);
      irq_if.pending_clr = 4'h0;
      chk("chg_setwin", 32'(irq_if.pending), 32'h1);
      irq_if.pending_clr = 4'h1;
      tick(1);
      irq_if.pending_clr = 4'h0;
      chk("chg_clr", 32'(irq_if.pending), 32'h0);

      // ch1 level-low re-sets under a continuous clear
      enable = 4'h2;
      sense_ctrl = 8'h5E;
      tick(1);
      chk("lvl_set", 32'(irq_if.pending), 32'h2);
      irq_if.pending_clr = 4'h2;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("lvl_reset", 32'(irq_if.pending), 32'h2);
      end
      int_pin[1] = 1'b1;
      tick(2);
      chk("lvl_tail", 32'(irq_if.pending), 32'h2);
      tick(1);
      chk("lvl_off", 32'(irq_if.pending), 32'h0);
      irq_if.pending_clr = 4'h0;

      // reset in the middle of a ch0 lockout
      enable = 4'h1;
      sense_ctrl = 8'h5D;
      debounce_en = 4'h1;
      debounce_limit = 16'd10;
      int_pin[0] = 1'b0;
      tick(3);
      chk("rl_set", 32'(irq_if.pending), 32'h1);
      tick(2);
      rst_n = 1'b0;
      tick(2);
      chk("rl_inrst", 32'(irq_if.pending), 32'h0);
      rst_n = 1'b1;
      tick(2);
      chk("rl_lat2", 32'(irq_if.pending), 32'h0);
      tick(1);
      chk("rl_fall", 32'(irq_if.pending), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ext_int_controller.md
EXT_INT_CONTROLLER -- requirements
Module: ext_int_controller

Interface
REQ-001 The block SHALL expose parameter NUM_CH, default 4, giving the number of interrupt channels (1..32).
REQ-002 The block SHALL expose parameter PIN_IDLE_STATE, NUM_CH bits, default all ones, giving the per-channel pin level loaded at reset.
REQ-003 The block SHALL expose parameter DEBOUNCE_W, default 16, giving the debounce counter width.
REQ-004 The block SHALL expose parameter SYNC_STAGES, default 2 (minimum 2), giving the input synchronizer depth.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port int_pin, input, NUM_CH bits: asynchronous external pins.
REQ-008 The block SHALL have port enable, input, NUM_CH bits: per-channel interrupt enable.
REQ-009 The block SHALL have port sense_ctrl, input, 2*NUM_CH bits: per-channel mode, 00 rise, 01 fall, 10 change, 11 level-low.
REQ-010 The block SHALL have port debounce_en, input, NUM_CH bits: per-channel debounce enable.
REQ-011 The block SHALL have port debounce_limit, input, DEBOUNCE_W bits: shared lockout length in cycles.
REQ-012 The block SHALL have port pending_clr, input, NUM_CH bits: write-1-to-clear pulses for the pending flags.
REQ-013 The block SHALL have port irq_ack, input, 1 bit: acknowledge, which clears pending[irq_id].
REQ-014 The block SHALL have port pending, output, NUM_CH bits: sticky per-channel pending flags.
REQ-015 The block SHALL have port irq_valid, output, 1 bit: high when any pending bit is set.
REQ-016 The block SHALL have port irq_id, output, max(1,$clog2(NUM_CH)) bits: index of the lowest-numbered pending channel.

Function
REQ-017 Each pin SHALL pass through a SYNC_STAGES flop synchronizer; prev SHALL hold the previous synchronized level.
REQ-018 Events SHALL be: rise = ~prev & sync; fall = prev & ~sync; change = prev ^ sync; level-low = ~sync on every cycle.
REQ-019 A detected event SHALL set pending[i] on the next clock edge, giving a pin-to-pending latency of SYNC_STAGES+1 cycles.
REQ-020 Each channel SHALL have states IDLE and LOCKOUT.
REQ-021 An edge event in IDLE with debounce_en[i]=1 and debounce_limit!=0 SHALL move the channel to LOCKOUT and clear its counter.
REQ-022 In LOCKOUT the counter SHALL increment each cycle and no events SHALL be reported.
REQ-023 When the counter equals debounce_limit-1, the channel SHALL return to IDLE and load prev with the current synchronized level, so bounce produces no spurious edge.
REQ-024 Debounce_limit=0 or debounce_en[i]=0 SHALL disable lockout for that channel.
REQ-025 Level-low mode SHALL bypass lockout and re-set pending every cycle the pin is low, including immediately after a clear.
REQ-026 A change of sense_ctrl SHALL take effect on the next cycle; a LOCKOUT already in progress SHALL run to completion.
REQ-027 While enable[i]=0 the channel SHALL be forced to IDLE, pending[i] SHALL be held at 0, and prev SHALL track the synchronized pin, so re-enabling produces no stale edge.
REQ-028 pending[i] SHALL clear when pending_clr[i]=1, or when irq_ack=1 and irq_id=i.
REQ-029 If a set and a clear hit the same bit in the same cycle, set SHALL win and pending[i] SHALL stay 1.
REQ-030 irq_valid and irq_id SHALL be combinational from pending, with a fixed lowest-index priority.
REQ-031 irq_id SHALL be 0 when pending is 0.
REQ-032 irq_ack with irq_valid=0 SHALL be ignored.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL load: synchronizer and prev = PIN_IDLE_STATE, state = IDLE, counter = 0, pending = 0; outputs are then irq_valid=0 and irq_id=0.
REQ-034 Reset during LOCKOUT SHALL abort the lockout, and the first edge after reset SHALL be judged against PIN_IDLE_STATE.

Structure
REQ-035 Package ext_int_pkg SHALL hold the sense_ctrl encoding constants, the channel state enum, and a function returning the priority-encoder index.
REQ-036 The per-channel synchronizer, edge detection, and lockout FSM/counter SHALL form sub-module ext_int_channel, instantiated NUM_CH times by a generate loop.
REQ-037 The top level SHALL hold the pending register, the clear logic, and the priority encoder.

Verification
REQ-038 Ch0 rise, no debounce, pin 0->1 -> pending[0]=1 exactly 3 cycles later (SYNC_STAGES=2), irq_valid=1, irq_id=0.
REQ-039 Ch1 fall, debounce_limit=10, pin toggles 5 times within 8 cycles then settles at 0 -> exactly one pending set, and no set after lockout ends.
REQ-040 Ch2 and ch3 pending, irq_ack -> irq_id goes 2 then 3, then irq_valid=0 after the second ack.
REQ-041 Ch0 change mode, pin edge coinciding with pending_clr[0] in the same cycle -> pending[0] remains 1.
REQ-042 Ch1 level-low, pin held low, pending_clr every cycle -> pending[1] re-sets each cycle; pin high then clear -> pending[1]=0.
REQ-043 rst_n asserted mid-lockout on ch0 with pin=0 and PIN_IDLE_STATE=1, then released -> no pending, and a subsequent fall edge is detected.
